// File: rtl/led_breathe_pwm.sv
// led_breathe_pwm
// Breathing LED driver: a PWM output whose duty ramps linearly from off to full
// brightness, holds, ramps back down to off, holds, and repeats forever.
//
// Parameters
//   PWM_BITS     width of the PWM counter and duty (MAX = 2^PWM_BITS-1)
//   PRESCALE     clk cycles per PWM counter step (>= 1)
//   STEP_PERIODS PWM periods per duty increment/decrement (>= 1)
//   HOLD_PERIODS PWM periods spent at duty MAX and at duty 0 (>= 1)
//
// Ports
//   clk          single clock, all state on posedge
//   rst          asynchronous active-high reset
//   en           run enable; low freezes counters, duty and phase
//   led          registered PWM output
//   duty         current duty value
//   phase        ramp state: 0 UP, 1 HOLD_HI, 2 DOWN, 3 HOLD_LO
//   period_tick  one-cycle pulse after each PWM period wrap
module led_breathe_pwm #(
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 16,
  parameter int STEP_PERIODS = 1,
  parameter int HOLD_PERIODS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          phase,
  output logic                period_tick
);

  typedef enum logic [1:0] {
    UP      = 2'd0,
    HOLD_HI = 2'd1,
    DOWN    = 2'd2,
    HOLD_LO = 2'd3
  } phase_e;

  localparam int PreW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int StepW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int HoldW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam int MaxVal = (1 << PWM_BITS) - 1;

  localparam logic [PreW-1:0]     PreLast    = PreW'(PRESCALE - 1);
  localparam logic [StepW-1:0]    StepLast   = StepW'(STEP_PERIODS - 1);
  localparam logic [HoldW-1:0]    HoldLast   = HoldW'(HOLD_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] PwmMax     = PWM_BITS'(MaxVal);
  localparam logic [PWM_BITS-1:0] PwmNearMax = PWM_BITS'(MaxVal - 1);
  localparam logic [PWM_BITS-1:0] PwmOne     = PWM_BITS'(1);

  logic [PreW-1:0]     pre_q,  pre_d;
  logic [PWM_BITS-1:0] pwm_q,  pwm_d;
  logic [StepW-1:0]    step_q, step_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  phase_e              state_q, state_d;
  logic                led_q,  led_d;
  logic                tick_q, tick_d;

  logic pwm_step;
  logic period_end;

  // State register: everything clears immediately on reset so the ramp
  // restarts from UP at duty 0 after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      pwm_q   <= '0;
      step_q  <= '0;
      hold_q  <= '0;
      duty_q  <= '0;
      state_q <= UP;
      led_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      pwm_q   <= pwm_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      duty_q  <= duty_d;
      state_q <= state_d;
      led_q   <= led_d;
      tick_q  <= tick_d;
    end
  end

  // Counter chain and ramp FSM. Duty and phase only move on the edge where the
  // PWM counter wraps, so every PWM period is generated with one stable duty.
  // With en low nothing advances; only led and period_tick are forced low.
  always_comb begin
    pwm_step   = en && (pre_q == PreLast);
    period_end = pwm_step && (pwm_q == PwmMax);

    pre_d   = pre_q;
    pwm_d   = pwm_q;
    step_d  = step_q;
    hold_d  = hold_q;
    duty_d  = duty_q;
    state_d = state_q;
    led_d   = en && (pwm_q < duty_q);
    tick_d  = period_end;

    if (en) begin
      pre_d = (pre_q == PreLast) ? '0 : pre_q + PreW'(1);
    end

    if (pwm_step) begin
      pwm_d = pwm_q + PwmOne;
    end

    if (period_end) begin
      case (state_q)
        UP: begin
          if (step_q == StepLast) begin
            step_d = '0;
            duty_d = duty_q + PwmOne;
            if (duty_q == PwmNearMax) begin
              state_d = HOLD_HI;
              hold_d  = '0;
            end
          end else begin
            step_d = step_q + StepW'(1);
          end
        end
        HOLD_HI: begin
          if (hold_q == HoldLast) begin
            hold_d  = '0;
            state_d = DOWN;
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end
        DOWN: begin
          if (step_q == StepLast) begin
            step_d = '0;
            duty_d = duty_q - PwmOne;
            if (duty_q == PwmOne) begin
              state_d = HOLD_LO;
              hold_d  = '0;
            end
          end else begin
            step_d = step_q + StepW'(1);
          end
        end
        HOLD_LO: begin
          if (hold_q == HoldLast) begin
            hold_d  = '0;
            state_d = UP;
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end
        default: state_d = UP;
      endcase
    end
  end

  assign led         = led_q;
  assign duty        = duty_q;
  assign phase       = state_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// tb_led_breathe_pwm
// Drives two breathing-LED instances (PRESCALE=2/STEP=1 and PRESCALE=1/STEP=3,
// both 3-bit PWM with 2 hold periods) from shared clk/rst/en and compares every
// output on every cycle against an arithmetic model based on the number of
// enabled clocks since reset, plus a set of hand-computed scenario checks.
module tb_led_breathe_pwm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  logic       ledA, tickA;
  logic [2:0] dutyA;
  logic [1:0] phaseA;
  logic       ledB, tickB;
  logic [2:0] dutyB;
  logic [1:0] phaseB;

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 1'b0;

  led_breathe_pwm #(.PWM_BITS(3), .PRESCALE(2), .STEP_PERIODS(1), .HOLD_PERIODS(2)) dutA (
    .clk(clk), .rst(rst), .en(en),
    .led(ledA), .duty(dutyA), .phase(phaseA), .period_tick(tickA)
  );

  led_breathe_pwm #(.PWM_BITS(3), .PRESCALE(1), .STEP_PERIODS(3), .HOLD_PERIODS(2)) dutB (
    .clk(clk), .rst(rst), .en(en),
    .led(ledB), .duty(dutyB), .phase(phaseB), .period_tick(tickB)
  );

  always #5 clk = ~clk;

  // Reference model: everything follows from e, the enabled edges since reset.
  function automatic int pwmCnt(input int e, input int pre, input int bits);
    return (e / pre) % (1 << bits);
  endfunction

  function automatic int isWrap(input int e, input int pre, input int bits);
    return ((e % pre) == pre - 1) && (pwmCnt(e, pre, bits) == (1 << bits) - 1);
  endfunction

  // Position inside the breathe cycle measured in completed PWM periods.
  function automatic int cyclePos(input int e, input int pre, input int bits,
                                  input int sp, input int hp);
    int mx;
    mx = (1 << bits) - 1;
    return (e / (pre << bits)) % (2 * mx * sp + 2 * hp);
  endfunction

  function automatic int modelDuty(input int e, input int pre, input int bits,
                                   input int sp, input int hp);
    int p, mx;
    mx = (1 << bits) - 1;
    p  = cyclePos(e, pre, bits, sp, hp);
    if (p < mx * sp) return p / sp;
    p -= mx * sp;
    if (p < hp) return mx;
    p -= hp;
    if (p < mx * sp) return mx - p / sp;
    return 0;
  endfunction

  function automatic int modelPhase(input int e, input int pre, input int bits,
                                    input int sp, input int hp);
    int p, mx;
    mx = (1 << bits) - 1;
    p  = cyclePos(e, pre, bits, sp, hp);
    if (p < mx * sp) return 0;
    if (p < mx * sp + hp) return 1;
    if (p < 2 * mx * sp + hp) return 2;
    return 3;
  endfunction

  int   eA = 0, eB = 0;
  logic expLedA = 1'b0, expTickA = 1'b0, expLedB = 1'b0, expTickB = 1'b0;

  // Model advance: registered outputs are formed from the pre-edge position.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eA <= 0; eB <= 0;
      expLedA <= 1'b0; expTickA <= 1'b0;
      expLedB <= 1'b0; expTickB <= 1'b0;
    end else if (en) begin
      expLedA  <= pwmCnt(eA, 2, 3) < modelDuty(eA, 2, 3, 1, 2);
      expTickA <= isWrap(eA, 2, 3) != 0;
      expLedB  <= pwmCnt(eB, 1, 3) < modelDuty(eB, 1, 3, 3, 2);
      expTickB <= isWrap(eB, 1, 3) != 0;
      eA <= eA + 1;
      eB <= eB + 1;
    end else begin
      expLedA <= 1'b0; expTickA <= 1'b0;
      expLedB <= 1'b0; expTickB <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic enV, input int cycles);
    en = enV;
    repeat (cycles) @(negedge clk);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("A_led",   32'(ledA),   32'(expLedA));
      checkOutput("A_tick",  32'(tickA),  32'(expTickA));
      checkOutput("A_duty",  32'(dutyA),  32'(modelDuty(eA, 2, 3, 1, 2)));
      checkOutput("A_phase", 32'(phaseA), 32'(modelPhase(eA, 2, 3, 1, 2)));
      checkOutput("B_led",   32'(ledB),   32'(expLedB));
      checkOutput("B_tick",  32'(tickB),  32'(expTickB));
      checkOutput("B_duty",  32'(dutyB),  32'(modelDuty(eB, 1, 3, 3, 2)));
      checkOutput("B_phase", 32'(phaseB), 32'(modelPhase(eB, 1, 3, 3, 2)));
    end
  end

  initial begin
    int n, ledSum, tickSum, prevPh, nChg;
    int chg[8];

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checking = 1'b1;
    checkOutput("rst_duty",  32'(dutyA),  0);
    checkOutput("rst_phase", 32'(phaseA), 0);
    checkOutput("rst_led",   32'(ledA),   0);
    checkOutput("rst_tick",  32'(tickA),  0);

    // First period after release: LED dark, one tick, duty steps to 1.
    rst = 1'b0;
    en  = 1'b1;
    ledSum = 0; tickSum = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      ledSum  += 32'(ledA);
      tickSum += 32'(tickA);
      if (i == 16) begin
        checkOutput("first_tick",  32'(tickA),  1);
        checkOutput("first_duty",  32'(dutyA),  1);
        checkOutput("first_phase", 32'(phaseA), 0);
      end
    end
    checkOutput("first_led_sum",  32'(ledSum),  0);
    checkOutput("first_tick_sum", 32'(tickSum), 1);

    // Duty 3: six high clocks per 16-clock period.
    n = 0;
    while (dutyA != 3'd3 && n < 100) begin @(negedge clk); n++; end
    checkOutput("wait_duty3", 32'(n < 100), 1);
    ledSum = 0;
    for (int i = 0; i < 16; i++) begin @(negedge clk); ledSum += 32'(ledA); end
    checkOutput("duty3_led_high", 32'(ledSum), 6);

    // Full breathe cycle: 288 clocks, phase 0 -> 1 -> 2 -> 3 -> 0.
    n = 0; prevPh = 32'(phaseA);
    while (n < 400) begin
      @(negedge clk); n++;
      if (prevPh == 3 && phaseA == 2'd0) break;
      prevPh = 32'(phaseA);
    end
    checkOutput("wait_cycle_start", 32'(n < 400), 1);
    n = 0; nChg = 0; prevPh = 32'(phaseA);
    while (n < 400) begin
      @(negedge clk); n++;
      if (32'(phaseA) != prevPh) begin
        if (nChg < 8) chg[nChg] = 32'(phaseA);
        nChg++;
        if (prevPh == 3 && phaseA == 2'd0) break;
        prevPh = 32'(phaseA);
      end
    end
    checkOutput("cycle_clks",    32'(n),    288);
    checkOutput("cycle_nphases", 32'(nChg), 4);
    for (int i = 0; i < 4; i++) checkOutput("cycle_phase_seq", 32'(chg[i]), 32'((i + 1) % 4));

    // Pause mid-DOWN at duty 4, five clocks into the period.
    n = 0;
    while (!(phaseA == 2'd2 && dutyA == 3'd4) && n < 400) begin @(negedge clk); n++; end
    checkOutput("wait_down4", 32'(n < 400), 1);
    applyStimulus(1'b1, 5);
    en = 1'b0;
    ledSum = 0; tickSum = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ledSum  += 32'(ledA);
      tickSum += 32'(tickA);
    end
    checkOutput("pause_led",   32'(ledSum),  0);
    checkOutput("pause_tick",  32'(tickSum), 0);
    checkOutput("pause_duty",  32'(dutyA),   4);
    checkOutput("pause_phase", 32'(phaseA),  2);
    en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!tickA && n < 40);
    checkOutput("resume_tick_delay", 32'(n), 11);
    checkOutput("resume_duty",       32'(dutyA), 3);

    // Asynchronous reset between edges during HOLD_HI.
    n = 0;
    while (phaseA != 2'd1 && n < 400) begin @(negedge clk); n++; end
    checkOutput("wait_hold_hi", 32'(n < 400), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_duty",   32'(dutyA),  0);
    checkOutput("async_phase",  32'(phaseA), 0);
    checkOutput("async_led",    32'(ledA),   0);
    checkOutput("async_tick",   32'(tickA),  0);
    checkOutput("async_B_duty", 32'(dutyB),  0);
    @(negedge clk);
    rst = 1'b0;

    // Instance B: 8-clock period, duty moves only on every third tick.
    tickSum = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      tickSum += 32'(tickB);
      if (i == 16) begin
        checkOutput("B_ticks16", 32'(tickSum), 2);
        checkOutput("B_duty16",  32'(dutyB),   0);
      end
      if (i == 24) begin
        checkOutput("B_ticks24", 32'(tickSum), 3);
        checkOutput("B_duty24",  32'(dutyB),   1);
        checkOutput("A_duty24",  32'(dutyA),   1);
      end
    end

    // Randomized enable pattern with occasional mid-cycle resets.
    for (int k = 0; k < 200; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        #3 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        applyStimulus(r < 75, $urandom_range(1, 40));
      end
    end

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
